// File: rtl/rr_mux8way16_if.sv
// Handshake bundle for the 8-way round-robin merge:
// eight producer channels in, one tagged word out.
interface rr_mux8way16_if #(
    parameter int WIDTH = 16
);
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/rr_mux8way16.sv
// Eight-way registered round-robin merge; each output word carries
// its 3-bit source index so a DMux8Way16 can route responses back.
module rr_mux8way16 #(
    parameter int WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    rr_mux8way16_if.slave     bus
);
    logic [2:0]       ptr;
    logic [2:0]       g;
    logic             found;
    logic             load;
    logic             xfer;
    logic [2:0]       idx;
    logic [WIDTH-1:0] gdata;

    assign load = !bus.out_valid || bus.out_ready;

    // First valid channel at or after ptr, wrapping 7->0.
    always_comb begin
        found = 1'b0;
        g     = 3'd0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign xfer  = found && load && reset_n;
    assign gdata = bus.in_data[g*WIDTH +: WIDTH];

    always_comb begin
        bus.in_ready = 8'h00;
        if (xfer)
            bus.in_ready[g] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= 3'd0;
            bus.out_data  <= '0;
            bus.out_sel   <= 3'd0;
            bus.out_valid <= 1'b0;
        end else if (xfer) begin
            bus.out_data  <= gdata;
            bus.out_sel   <= g;
            bus.out_valid <= 1'b1;
            ptr           <= g + 3'd1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/rr_mux8way16.md
Name: rr_mux8way16

Overview:
- Eight-way, 16-bit registered merge. It is the gather-side counterpart to the 8-way 16-bit demux path.
- Eight producer channels, each with a valid/ready handshake, are arbitrated round-robin onto one output channel.
- Each output word is tagged with a 3-bit source index. The index uses the same encoding as the demux `sel`, so responses can be routed back by a downstream DMux8Way16.
- It sits between the per-channel request sources and a single shared consumer (bus, memory port or ALU input).

Parameters:
WIDTH, 16, data width of each input channel and of the output.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_data  input  8*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_valid  input  8  per-channel request valid.
in_ready  output  8  per-channel accept. One-hot or zero; combinational.
out_data  output  WIDTH  registered output word.
out_sel  output  3  registered source channel index of out_data.
out_valid  output  1  registered output valid.
out_ready  input  1  consumer accept.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready forced to 8'h00 while reset_n is low.
- Load enable: load = !out_valid || out_ready.
  - The output register accepts a new word when it is empty or is being drained in the same cycle.
- Arbitration (combinational, evaluated every cycle):
  - Search in_valid starting at index ptr, ascending, wrapping 7->0.
  - The first set bit is the candidate g.
  - in_ready[g] = load, when a candidate exists. All other in_ready bits are 0.
- Transfer on a channel: in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data <= channel i data;
  - out_sel <= i;
  - out_valid <= 1;
  - ptr <= (i+1) mod 8.
- Output drained with no new transfer (out_valid && out_ready, no candidate):
  - out_valid <= 0.
  - out_data and out_sel hold their last values.
  - ptr unchanged.
- Stall (out_valid && !out_ready):
  - out_data, out_sel and out_valid hold.
  - in_ready=0.
  - ptr unchanged.
- No candidate while load is high:
  - ptr unchanged.
  - out_valid <= 0 if the current word is drained.
- Latency and throughput:
  - 1 cycle from transfer edge to out_valid.
  - Sustained throughput is 1 word/cycle while out_ready stays high.
  - No bubble is inserted on simultaneous drain and load.
- Fairness: a channel that holds in_valid is granted within 8 transfers.
- Producer rules (not checked by the block):
  - Once in_valid[i] is raised, it and channel i data stay stable until accepted.
  - in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Simultaneous events:
  - Multiple in_valid bits: exactly one grant per cycle.
  - Drain plus new transfer in the same cycle: the new word replaces the old, and out_valid stays 1.
- Reset mid-operation:
  - The pending output word is discarded immediately and out_valid drops asynchronously.
  - ptr returns to 0.
  - No transfer occurs on any edge while reset_n is low.
- Widths: ptr and out_sel are 3 bits, so the increment wraps naturally from 7 to 0.

Test Plan:
1. Reset: drive reset_n=0 asynchronously mid-cycle with all in_valid=1 -> immediately out_valid=0, out_data=0, out_sel=0, in_ready=8'h00; after release the first grant goes to channel 0.
2. Single channel: in_valid=8'b0010_0000, ch5 data=16'hBEEF, out_ready=1 -> in_ready=8'b0010_0000 that cycle; next cycle out_valid=1, out_data=16'hBEEF, out_sel=5.
3. Full round-robin: in_valid=8'hFF held, ch i data=16'h1000+i, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles with out_data=16'h1000+out_sel, and no idle cycles.
4. Backpressure: word from ch3 registered, out_ready=0 for 4 cycles with ch1 and ch6 valid -> out_data/out_sel stable at ch3 values and in_ready=0; when out_ready=1, ch6 is granted that same cycle (ptr=4), then ch1 is granted.
5. Pointer wrap: last grant ch6, then in_valid=8'b1000_0100 -> ch7 granted first, then ch2; ptr ends at 3.
6. Drain to empty: single word out, then in_valid=0, out_ready=1 -> out_valid=0 next cycle; out_data holds its last value and ptr is unchanged.
